// File: rtl/ms_section_writer.sv
// Alternating-section master-slave writer: bursts of BURST_LEN incrementing writes on
// m_out (section A), then BURST_LEN decrementing writes on m_out2 (section B), repeat.
module ms_section_writer #(
  parameter int unsigned        BURST_LEN = 4,
  parameter logic signed [31:0] INIT_VAL  = 32'sd1337
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  output logic signed [31:0] m_out,
  output logic               m_out_notify,
  output logic signed [31:0] m_out2,
  output logic               m_out2_notify,
  output logic               section_o
);

  typedef enum logic {
    SECTION_A = 1'b0,
    SECTION_B = 1'b1
  } section_e;

  localparam logic [7:0] CNT_LAST = 8'(BURST_LEN - 1);

  section_e           section_q, section_d;
  logic signed [31:0] val_q, val_d;
  logic [7:0]         cnt_q, cnt_d;
  logic signed [31:0] m_out_q, m_out_d;
  logic signed [31:0] m_out2_q, m_out2_d;
  logic               notify_q, notify_d;
  logic               notify2_q, notify2_d;
  logic               section_o_q, section_o_d;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through this block infers a latch.
    section_d   = section_q;
    val_d       = val_q;
    cnt_d       = cnt_q;
    m_out_d     = m_out_q;
    m_out2_d    = m_out2_q;
    notify_d    = 1'b0;
    notify2_d   = 1'b0;
    section_o_d = section_o_q;

    if (!hold) begin
      // section_o follows the section of the write on the bus, not the next one.
      section_o_d = (section_q == SECTION_B);
      if (section_q == SECTION_A) begin
        m_out_d  = val_q;
        notify_d = 1'b1;
        val_d    = val_q + 32'sd1;
      end else begin
        m_out2_d  = val_q;
        notify2_d = 1'b1;
        val_d     = val_q - 32'sd1;
      end

      if (cnt_q == CNT_LAST) begin
        cnt_d     = 8'd0;
        section_d = (section_q == SECTION_A) ? SECTION_B : SECTION_A;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      section_q   <= SECTION_A;
      val_q       <= INIT_VAL;
      cnt_q       <= 8'd0;
      m_out_q     <= '0;
      m_out2_q    <= '0;
      notify_q    <= 1'b0;
      notify2_q   <= 1'b0;
      section_o_q <= 1'b0;
    end else begin
      section_q   <= section_d;
      val_q       <= val_d;
      cnt_q       <= cnt_d;
      m_out_q     <= m_out_d;
      m_out2_q    <= m_out2_d;
      notify_q    <= notify_d;
      notify2_q   <= notify2_d;
      section_o_q <= section_o_d;
    end
  end

  assign m_out         = m_out_q;
  assign m_out2        = m_out2_q;
  assign m_out_notify  = notify_q;
  assign m_out2_notify = notify2_q;
  assign section_o     = section_o_q;

endmodule

// File: doc/ms_section_writer.md
MS_SECTION_WRITER -- requirements
Module: ms_section_writer

Interface
REQ-001 Parameter BURST_LEN, default 4, writes per section, legal range 1..255.
REQ-002 Parameter INIT_VAL, default 1337, 32-bit signed value loaded into the value register at reset.
REQ-003 clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 hold  input  1  when high, stalls the block with no write that cycle.
REQ-006 m_out  output  32 (signed)  master-slave data toward the section-A consumer.
REQ-007 m_out_notify  output  1  high for exactly the cycles in which m_out carries a new write.
REQ-008 m_out2  output  32 (signed)  master-slave data toward the section-B consumer.
REQ-009 m_out2_notify  output  1  high for exactly the cycles in which m_out2 carries a new write.
REQ-010 section_o  output  1  current section: 0 = SECTION_A, 1 = SECTION_B.

Function
REQ-011 Internal state SHALL comprise the section register (SECTION_A/SECTION_B), the 32-bit signed val register and an 8-bit write counter cnt.
REQ-012 All outputs SHALL be registered; a write decided at edge N is visible from edge N to edge N+1.
REQ-013 Writes are non-blocking master-slave transfers: no acknowledge, and the consumer samples data whenever its notify is high.
REQ-014 SECTION_A, hold=0 at an edge: m_out<=val, m_out_notify<=1, m_out2_notify<=0, val<=val+1, cnt<=cnt+1.
REQ-015 SECTION_B, hold=0 at an edge: m_out2<=val, m_out2_notify<=1, m_out_notify<=0, val<=val-1, cnt<=cnt+1.
REQ-016 Section transition: when a write occurs with cnt==BURST_LEN-1, cnt<=0 and the section toggles (A->B or B->A) at the same edge.
REQ-017 Only SECTION_A->SECTION_B and SECTION_B->SECTION_A transitions SHALL exist; no other states are reachable.
REQ-018 hold=1 (rst=0) at an edge: both notifies<=0, and m_out, m_out2, val, cnt and section all keep their values.
REQ-019 The data output of the inactive section SHALL keep its last written value.
REQ-020 val arithmetic SHALL be 32-bit two's complement with silent wrap: 0x7FFFFFFF+1 = 0x80000000 and 0x80000000-1 = 0x7FFFFFFF.
REQ-021 At most one notify SHALL be high in any cycle.
REQ-022 section_o SHALL reflect the section register, so it changes in the same cycle as the first notify of the new section.
REQ-023 First-write latency: the first rising edge with rst=0 and hold=0 after reset produces m_out=INIT_VAL with m_out_notify=1 in the following cycle.

Reset
REQ-024 rst=1 at an edge SHALL set m_out=0, m_out2=0, m_out_notify=0, m_out2_notify=0, section_o=0 (SECTION_A), val=INIT_VAL and cnt=0.
REQ-025 rst SHALL take priority over hold and over any in-progress section or burst.
REQ-026 Reset mid-burst SHALL discard the partial burst; operation restarts at SECTION_A with cnt=0.

Verification
REQ-027 Defaults, rst for 2 cycles, then hold=0 for 9 cycles -> m_out_notify on cycles 1-4 with m_out 1337, 1338, 1339, 1340; m_out2_notify on cycles 5-8 with m_out2 1341, 1340, 1339, 1338; cycle 9 m_out=1337 with section_o=0.
REQ-028 Defaults, hold=1 only on cycle 3 -> no notify on cycle 3 and m_out stays 1338; cycles 4-5 write 1339 and 1340; section B starts on cycle 6.
REQ-029 INIT_VAL=0x7FFFFFFE, BURST_LEN=4 -> m_out 0x7FFFFFFE, 0x7FFFFFFF, 0x80000000, 0x80000001, then m_out2 0x80000002, 0x80000001, 0x80000000, 0x7FFFFFFF.
REQ-030 Defaults, rst pulsed during the 2nd SECTION_B write -> next cycle all outputs 0 and section_o=0; the next write is m_out=1337.
REQ-031 BURST_LEN=1 -> strict alternation: m_out 1337, m_out2 1338, m_out 1337, m_out2 1338, with section_o toggling every cycle.
REQ-032 rst=1 and hold=1 together, then both released -> reset values apply; the first write after release is m_out=1337.
